// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 hasher types, round constants and mixing helpers
package sha256_pkg;

  // Word 0 (a) sits in the least significant 32 bits.
  typedef logic [7:0][31:0] WorkingVars;
  // Message word i sits at block[i]; block[0] is the first word on the wire.
  typedef logic [15:0][31:0] MessageWords;

  typedef struct packed {
    logic        firstBlock;
    logic        lastBlock;
    MessageWords block;
  } HasherBlock;

  typedef enum logic [2:0] {
    Idle,
    Rounds,
    Update,
    Second,
    Output
  } HasherState;

  localparam logic [31:0] ROUNDING_CONSTANTS [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Listed h..a so that index 0 is a.
  localparam WorkingVars INITIAL_VARS = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  // Words 8..15 of the second-pass block: padding bit, zeros, 256-bit length.
  localparam logic [7:0][31:0] PAD_BLOCK2 = {32'h00000100, {6{32'h0}}, 32'h80000000};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bigSigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bigSigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] smallSigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] smallSigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_round_unroll.sv
// rtl/sha256_round_unroll.sv - R chained SHA-256 rounds plus R-word schedule advance
module sha256_round_unroll
  import sha256_pkg::*;
#(
  parameter int R = 1
) (
  input  logic [5:0]  roundIdx,
  input  WorkingVars  vars,
  input  MessageWords window,
  output WorkingVars  varsNext,
  output MessageWords windowNext
);

  // Extend the 16-word window by R words (later words may depend on earlier new ones) and slide it.
  always_comb begin
    logic [31:0] ext [16 + R];
    for (int i = 0; i < 16; i++) ext[i] = window[i];
    for (int r = 0; r < R; r++) begin
      ext[16 + r] = smallSigma1(ext[14 + r]) + ext[9 + r] + smallSigma0(ext[1 + r]) + ext[r];
    end
    for (int i = 0; i < 16; i++) windowNext[i] = ext[i + R];
  end

  // Apply rounds roundIdx..roundIdx+R-1 back to back; window[r] is W for round roundIdx+r.
  always_comb begin
    WorkingVars  v;
    logic [31:0] t1;
    logic [31:0] t2;
    logic [5:0]  kIdx;
    v    = vars;
    t1   = '0;
    t2   = '0;
    kIdx = roundIdx;
    for (int r = 0; r < R; r++) begin
      kIdx = roundIdx + 6'(r);
      t1 = v[7] + bigSigma1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + ROUNDING_CONSTANTS[kIdx] + window[r];
      t2 = bigSigma0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v  = {v[6:4], v[3] + t1, v[2:0], t1 + t2};
    end
    varsNext = v;
  end

endmodule

// File: rtl/sha256_hasher_multi.sv
// rtl/sha256_hasher_multi.sv - multi-round-per-clock SHA-256 block hasher with midstate and double hash
module sha256_hasher_multi
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int DOUBLE_HASH      = 1,
  parameter int MIDSTATE_EN      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       validIn,
  output logic       readyOut,
  input  HasherBlock dataIn,
  input  logic       useMidstate,
  input  WorkingVars midstateIn,
  input  logic       readyHashIn,
  output logic       validHashOut,
  output WorkingVars hashOut
);

  localparam logic [5:0] STEP       = 6'(ROUNDS_PER_CYCLE);
  localparam logic [5:0] LAST_ROUND = 6'(64 - ROUNDS_PER_CYCLE);

  HasherState  state;
  logic [5:0]  roundIdx;
  WorkingVars  vars;
  WorkingVars  chain;
  MessageWords window;
  logic        blockLast;
  logic        secondPass;

  WorkingVars  varsNext;
  MessageWords windowNext;
  WorkingVars  seedVars;

  assign seedVars = ((MIDSTATE_EN != 0) && useMidstate) ? midstateIn : INITIAL_VARS;

  sha256_round_unroll #(.R(ROUNDS_PER_CYCLE)) roundUnroll (
    .roundIdx  (roundIdx),
    .vars      (vars),
    .window    (window),
    .varsNext  (varsNext),
    .windowNext(windowNext)
  );

  // Block FSM: accept a block, run 64 rounds, fold into the chain, optionally rehash, then present the digest.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= Idle;
      roundIdx     <= '0;
      vars         <= '0;
      chain        <= '0;
      window       <= '0;
      blockLast    <= 1'b0;
      secondPass   <= 1'b0;
      readyOut     <= 1'b0;
      validHashOut <= 1'b0;
      hashOut      <= '0;
    end else begin
      case (state)
        Idle: begin
          if (validIn && readyOut) begin
            window     <= dataIn.block;
            blockLast  <= dataIn.lastBlock;
            secondPass <= 1'b0;
            roundIdx   <= '0;
            readyOut   <= 1'b0;
            state      <= Rounds;
            // A first block restarts the chain even if a message was in progress.
            if (dataIn.firstBlock) begin
              chain <= seedVars;
              vars  <= seedVars;
            end else begin
              vars <= chain;
            end
          end else begin
            readyOut <= 1'b1;
          end
        end
        Rounds: begin
          vars     <= varsNext;
          window   <= windowNext;
          roundIdx <= roundIdx + STEP;
          if (roundIdx == LAST_ROUND) state <= Update;
        end
        Update: begin
          for (int i = 0; i < 8; i++) chain[i] <= chain[i] + vars[i];
          if (!blockLast) begin
            state    <= Idle;
            readyOut <= 1'b1;
          end else if ((DOUBLE_HASH != 0) && !secondPass) begin
            state <= Second;
          end else begin
            state <= Output;
          end
        end
        Second: begin
          // The first digest becomes a padded 32-byte message hashed from the IV.
          window     <= {PAD_BLOCK2, chain};
          chain      <= INITIAL_VARS;
          vars       <= INITIAL_VARS;
          secondPass <= 1'b1;
          roundIdx   <= '0;
          state      <= Rounds;
        end
        Output: begin
          if (!validHashOut) begin
            validHashOut <= 1'b1;
            hashOut      <= chain;
          end else if (readyHashIn) begin
            validHashOut <= 1'b0;
            readyOut     <= 1'b1;
            state        <= Idle;
          end
        end
        default: state <= Idle;
      endcase
    end
  end

endmodule
